// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit pipelined MIPS front end.
package mips_pkg;

  localparam int DEF_INSTR_W = 16;
  localparam int DEF_PC_W = 16;
  localparam int DEF_PC_INC = 2;
  localparam int unsigned DEF_RESET_PC = 0;

  // One buffered fetch: the instruction and the address of its successor.
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_PC_W-1:0]    pc_next;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with occupancy count and synchronous flush.
// Storage is reset so the head never reads X, even when empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A push into a full queue is legal only when the head leaves this cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Pointers, count and storage; flush discards everything but the write slot stays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the PC, issues one lookup per cycle and
// buffers {instr, pc+PC_INC} in a queue that a taken branch flushes.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both 1
// at the rising edge. Decode side: out_vld/out_rdy, out_vld never depends on
// out_rdy. Memory side: imem_req is the valid, imem_hit the same-cycle
// response; imem_req depends combinationally on out_rdy (a pop frees a slot).
module fetch_queue_unit
  import mips_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_W = DEF_PC_W,
  parameter int DEPTH = 4,
  parameter int PC_INC = DEF_PC_INC,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_vld,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic                   imem_hit,
  input  logic [INSTR_W-1:0]     imem_rdata,
  output logic                   out_vld,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [PC_W-1:0]        out_pc_next,
  input  logic                   out_rdy,
  output logic [$clog2(DEPTH):0] q_count
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_next;
  } entry_t;

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  entry_t          wr_entry;
  entry_t          head;

  assign pc_inc    = pc + PC_W'(PC_INC);
  assign imem_addr = pc;

  assign out_vld     = ~empty;
  assign out_instr   = head.instr;
  assign out_pc_next = head.pc_next;

  // No lookup while in reset; otherwise look up whenever a slot is or becomes free.
  assign pop      = out_vld & out_rdy;
  assign imem_req = rst_n & (~full | pop);
  assign push     = imem_req & imem_hit & ~redirect_vld;

  assign wr_entry = '{instr: imem_rdata, pc_next: pc_inc};

  // PC: a redirect wins, a hit advances, a miss holds the address stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= PC_W'(RESET_PC);
    else if (redirect_vld) pc <= redirect_pc;
    else if (push) pc <= pc_inc;
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .W($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_vld),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

endmodule
